// File: rtl/bist_responder_pkg.sv
// Shared BIST definitions: responder widths, table geometry and the
// next-state rule applied when a transition-table entry is not programmed.
package bist_responder_pkg;

   localparam int BIST_STATE_W   = 4;
   localparam int BIST_TBL_AW    = 2 * BIST_STATE_W;
   localparam int BIST_TBL_DEPTH = 1 << BIST_TBL_AW;

   typedef logic [BIST_STATE_W-1:0] bist_state_t;

   // How the state register moves on a given cycle.
   typedef enum logic [1:0] {
      STEP_HOLD = 2'd0,   // enable low: nothing moves
      STEP_SET  = 2'd1,   // load the symbol directly as the new state
      STEP_TBL  = 2'd2,   // programmed table entry
      STEP_DFLT = 2'd3    // unprogrammed entry: arithmetic fallback
   } bist_step_e;

   // Fallback transition: state advances by the symbol, modulo 2^STATE_W.
   function automatic bist_state_t bist_dflt_next(input bist_state_t s,
                                                  input bist_state_t sym);
      return s + sym;
   endfunction

endpackage

// File: rtl/bist_resp_table.sv
// Transition table: DEPTH x DW RAM with a per-entry valid bit.
// One write port, one asynchronous read port; clr_i wipes the valid bits
// and blocks writes. Reads see the pre-write contents in the write cycle.
module bist_resp_table
   import bist_responder_pkg::*;
#(
   parameter int AW    = BIST_TBL_AW,
   parameter int DW    = BIST_STATE_W,
   parameter int DEPTH = 1 << AW
) (
   input  logic          clk,
   input  logic          clr_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o,
   output logic          rvalid_o
);

   logic [DW-1:0]    mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic             wr_en;

   assign wr_en = we_i && !clr_i;

   // Data array: no reset, contents only matter once the valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[waddr_i] <= wdata_i;
   end

   // Valid bits: cleared wholesale by clr_i, set by each accepted write.
   always_ff @(posedge clk) begin
      if (clr_i)      valid_q          <= '0;
      else if (wr_en) valid_q[waddr_i] <= 1'b1;
   end

   assign rdata_o  = mem_q[raddr_i];
   assign rvalid_o = valid_q[raddr_i];

endmodule

// File: rtl/bist_responder.sv
// BIST responder: a small state machine-under-test driven by BIST stimulus.
// Each enabled cycle either loads a state directly or follows a programmable
// transition table (with an arithmetic fallback), and reports the resulting
// state back with optional stuck-at-1 fault injection.
module bist_responder
   import bist_responder_pkg::*;
#(
   parameter int STATE_W = BIST_STATE_W,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 TLR,
   input  logic                 RESET_SM,
   input  logic                 enable,
   input  logic [STATE_W:0]     BIST_OUT,
   output logic [STATE_W-1:0]   BIST_IN,
   input  logic                 tbl_we,
   input  logic [2*STATE_W-1:0] tbl_addr,
   input  logic [STATE_W-1:0]   tbl_data,
   input  logic                 fault_en,
   input  logic [STATE_W-1:0]   fault_mask,
   output logic [CNT_W-1:0]     step_cnt,
   output logic                 busy
);

   logic [STATE_W-1:0]   state_q, state_d;
   logic [CNT_W-1:0]     step_cnt_q, step_cnt_d;
   logic                 busy_q, busy_d;

   logic [STATE_W-1:0]   sym;
   logic                 set_flag;
   logic [2*STATE_W-1:0] rd_addr;
   logic [STATE_W-1:0]   rd_data;
   logic                 rd_valid;
   bist_step_e           step;

   bist_resp_table #(
      .AW (2*STATE_W),
      .DW (STATE_W)
   ) u_tbl (
      .clk      (clk),
      .clr_i    (TLR),
      .we_i     (tbl_we),
      .waddr_i  (tbl_addr),
      .wdata_i  (tbl_data),
      .raddr_i  (rd_addr),
      .rdata_o  (rd_data),
      .rvalid_o (rd_valid)
   );

   // Decode the stimulus and compute next state, step count and busy.
   always_comb begin
      sym        = BIST_OUT[STATE_W:1];
      set_flag   = BIST_OUT[0];
      rd_addr    = {state_q, sym};
      step       = STEP_HOLD;
      state_d    = state_q;
      step_cnt_d = step_cnt_q;
      busy_d     = busy_q;

      if (enable) begin
         if (set_flag)      step = STEP_SET;
         else if (rd_valid) step = STEP_TBL;
         else               step = STEP_DFLT;
      end

      case (step)
         STEP_SET:  state_d = sym;
         STEP_TBL:  state_d = rd_data;
         STEP_DFLT: state_d = bist_dflt_next(state_q, sym);
         default:   state_d = state_q;
      endcase

      if (step != STEP_HOLD) begin
         busy_d = 1'b1;
         // Saturate rather than wrap so a long run never looks short.
         if (!(&step_cnt_q))
            step_cnt_d = step_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // State registers; either reset discards the concurrent step.
   always_ff @(posedge clk) begin
      if (TLR || RESET_SM) begin
         state_q    <= '0;
         step_cnt_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_cnt_q <= step_cnt_d;
         busy_q     <= busy_d;
      end
   end

   assign BIST_IN  = fault_en ? (state_q | fault_mask) : state_q;
   assign step_cnt = step_cnt_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_bist_responder.sv
// Directed bench for bist_responder: stepping, table programming,
// read-before-write, resets, fault masking and counter saturation.
module tb_bist_responder;

   logic        clk = 1'b0;
   logic        TLR, RESET_SM, enable;
   logic [4:0]  BIST_OUT;
   logic [3:0]  BIST_IN;
   logic        tbl_we;
   logic [7:0]  tbl_addr;
   logic [3:0]  tbl_data;
   logic        fault_en;
   logic [3:0]  fault_mask;
   logic [15:0] step_cnt;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   bist_responder #(.STATE_W(4), .CNT_W(16)) dut (
      .clk        (clk),
      .TLR        (TLR),
      .RESET_SM   (RESET_SM),
      .enable     (enable),
      .BIST_OUT   (BIST_OUT),
      .BIST_IN    (BIST_IN),
      .tbl_we     (tbl_we),
      .tbl_addr   (tbl_addr),
      .tbl_data   (tbl_data),
      .fault_en   (fault_en),
      .fault_mask (fault_mask),
      .step_cnt   (step_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: inputs already set, returns at the following negedge.
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      TLR = 1'b1; RESET_SM = 1'b0; enable = 1'b0; BIST_OUT = '0;
      tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
      fault_en = 1'b0; fault_mask = '0;
      cyc(); cyc();
      TLR = 1'b0;
      chk("rst_state", BIST_IN, 4'h0);
      chk("rst_cnt", step_cnt, 16'd0);
      chk("rst_busy", busy, 1'b0);

      // Default rule stepping by 3.
      enable = 1'b1; BIST_OUT = {4'h3, 1'b0};
      cyc(); chk("dflt_1", BIST_IN, 4'h3); chk("busy_1st", busy, 1'b1);
      cyc(); chk("dflt_2", BIST_IN, 4'h6);
      cyc(); chk("dflt_3", BIST_IN, 4'h9); chk("cnt_3", step_cnt, 16'd3);

      // Enable low: hold regardless of stimulus.
      enable = 1'b0; BIST_OUT = {4'hF, 1'b1};
      cyc(); chk("hold_state", BIST_IN, 4'h9); chk("hold_cnt", step_cnt, 16'd3);

      // RESET_SM with a concurrent table write: write still lands.
      RESET_SM = 1'b1; enable = 1'b1;
      tbl_we = 1'b1; tbl_addr = 8'h05; tbl_data = 4'hA;
      cyc(); chk("rsm_state", BIST_IN, 4'h0); chk("rsm_cnt", step_cnt, 16'd0);
      chk("rsm_busy", busy, 1'b0);
      RESET_SM = 1'b0; tbl_we = 1'b0;

      BIST_OUT = {4'h5, 1'b0};
      cyc(); chk("tbl_hit", BIST_IN, 4'hA); chk("tbl_cnt", step_cnt, 16'd1);

      // Set-state, then RESET_SM discarding a concurrent step.
      BIST_OUT = {4'hC, 1'b1};
      cyc(); chk("set_C", BIST_IN, 4'hC); chk("set_cnt", step_cnt, 16'd2);
      RESET_SM = 1'b1;
      cyc(); chk("rsm2_state", BIST_IN, 4'h0); chk("rsm2_cnt", step_cnt, 16'd0);
      RESET_SM = 1'b0; BIST_OUT = {4'h5, 1'b0};
      cyc(); chk("tbl_retained", BIST_IN, 4'hA);

      // Unprogrammed entry from A: (A + 7) mod 16 = 1.
      BIST_OUT = {4'h7, 1'b0};
      cyc(); chk("dflt_wrap", BIST_IN, 4'h1);

      // Read-before-write on {0,5}.
      BIST_OUT = {4'h0, 1'b1};
      cyc(); chk("set_0", BIST_IN, 4'h0);
      BIST_OUT = {4'h5, 1'b0}; tbl_we = 1'b1; tbl_addr = 8'h05; tbl_data = 4'h7;
      cyc(); chk("rbw_old", BIST_IN, 4'hA);
      tbl_we = 1'b0; BIST_OUT = {4'h0, 1'b1};
      cyc();
      BIST_OUT = {4'h5, 1'b0};
      cyc(); chk("rbw_new", BIST_IN, 4'h7);

      // Fault injection is combinational.
      BIST_OUT = {4'h3, 1'b1};
      cyc(); enable = 1'b0;
      fault_en = 1'b1; fault_mask = 4'h8;
      #1 chk("fault_on", BIST_IN, 4'hB);
      fault_en = 1'b0;
      #1 chk("fault_off", BIST_IN, 4'h3);
      fault_mask = 4'h0;

      // TLR clears valid bits and blocks writes.
      TLR = 1'b1; enable = 1'b1; BIST_OUT = {4'h1, 1'b1};
      tbl_we = 1'b1; tbl_addr = 8'h15; tbl_data = 4'hF;
      cyc(); chk("tlr_state", BIST_IN, 4'h0); chk("tlr_busy", busy, 1'b0);
      TLR = 1'b0; tbl_we = 1'b0;
      BIST_OUT = {4'h5, 1'b0};
      cyc(); chk("tlr_valid_clr", BIST_IN, 4'h5);
      BIST_OUT = {4'h1, 1'b1};
      cyc();
      BIST_OUT = {4'h5, 1'b0};
      cyc(); chk("tlr_wr_block", BIST_IN, 4'h6);

      // Counter saturation.
      TLR = 1'b1;
      cyc();
      TLR = 1'b0; BIST_OUT = {4'h0, 1'b1};
      repeat (65534) cyc();
      chk("cnt_fffe", step_cnt, 16'hFFFE);
      cyc(); chk("cnt_sat1", step_cnt, 16'hFFFF);
      cyc(); chk("cnt_sat2", step_cnt, 16'hFFFF);
      cyc(); chk("cnt_sat3", step_cnt, 16'hFFFF);
      chk("busy_sat", busy, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
